// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared encodings and helpers for the data-memory responder:
//             access-size codes, FSM states, latency-counter width, request
//             error check, lane offset, byte enables, store-data steering and
//             load extension.
//  Config   : DMEM_MISALIGN_CHK_EN - when defined, misaligned half/word
//             accesses are reported as errors instead of being force-aligned.
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Latency counter width; covers the legal LATENCY range 1..15.
  localparam int LAT_W = 4;

  // Reserved size or out-of-range word index (plus misalignment when enabled).
  function automatic logic req_is_err(input logic [1:0] size, input logic [31:0] addr,
                                      input int depth);
    logic err;
    err = (size == SZ_RSVD) || ({2'b00, addr[31:2]} >= 32'(depth));
`ifdef DMEM_MISALIGN_CHK_EN
    if ((size == SZ_HALF) && addr[0]) err = 1'b1;
    if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) err = 1'b1;
`endif
    return err;
  endfunction

  // Byte lane of the access; half/word low bits are forced to alignment.
  function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] a);
    logic [1:0] off;
    case (size)
      SZ_BYTE: off = a;
      SZ_HALF: off = {a[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across all lanes; byte enables pick the lane.
  function automatic logic [31:0] steer_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wd[7:0]}};
      SZ_HALF: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] extend(input logic [1:0] size, input logic sext,
                                         input logic [1:0] off, input logic [31:0] q);
    logic [31:0] sh;
    logic [31:0] d;
    sh = q >> {off, 3'b000};
    case (size)
      SZ_BYTE: d = {{24{sext & sh[7]}}, sh[7:0]};
      SZ_HALF: d = {{16{sext & sh[15]}}, sh[15:0]};
      default: d = q;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder_if
//  Purpose  : Request/response bundle between the mem-access stage (master)
//             and the data-memory responder (slave).
//  Signals  : req_valid/req_ready handshake, req_wen, req_size[1:0],
//             req_sign_ext, req_addr[31:0], req_wdata[31:0];
//             resp_valid pulse, resp_rdata[31:0], resp_err.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_sign_ext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_size, req_sign_ext, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_size, req_sign_ext, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_array
//  Purpose  : DEPTH_WORDS x 32 synchronous RAM, byte-enable write and
//             registered read port. Contents are not reset.
//  Ports    : clk; i_en access strobe; i_we write; i_be[3:0] byte enables;
//             i_idx word index; i_wdata write data; o_rdata registered read.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  wire logic          clk,
  input  wire logic          i_en,
  input  wire logic          i_we,
  input  wire logic [3:0]    i_be,
  input  wire logic [AW-1:0] i_idx,
  input  wire logic [31:0]   i_wdata,
  output logic      [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Memory-side responder: accepts one load/store at a time, waits
//             LATENCY cycles, then pulses resp_valid with extended load data,
//             a store ack, or an error. Handles lane steering, byte enables
//             and sign/zero extension.
//  Ports    : clk, rst (sync, active high); bus (dmem_responder_if.slave).
//  Params   : DEPTH_WORDS (words in array), LATENCY (1..15).
//  Config   : DMEM_MISALIGN_CHK_EN - report misaligned half/word as errors.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input wire logic          clk,
  input wire logic          rst,
  dmem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] c_cnt_last = LAT_W'(LATENCY - 2);

  state_e           r_state;
  logic [LAT_W-1:0] r_cnt;
  logic             r_wen;
  logic [1:0]       r_size;
  logic             r_sext;
  logic [1:0]       r_off;
  logic             r_err;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  logic             w_ready;
  logic             w_accept;
  logic             w_go_resp;
  logic             w_from_req;
  logic             w_s_wen;
  logic [1:0]       w_s_size;
  logic [31:0]      w_s_addr;
  logic [31:0]      w_s_wdata;
  logic             w_s_err;
  logic [1:0]       w_s_off;
  logic [31:0]      w_q;

  assign w_ready  = (r_state == IDLE) && !rst;
  assign w_accept = bus.req_valid && w_ready;

  // The array access happens on the edge entering RESP. With LATENCY=1 that is
  // the accept edge itself, so the live request feeds the array instead of the
  // registered copy.
  assign w_go_resp = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                     ((r_state == WAIT) && (r_cnt == c_cnt_last));
  assign w_from_req = (r_state == IDLE);
  assign w_s_wen    = w_from_req ? bus.req_wen   : r_wen;
  assign w_s_size   = w_from_req ? bus.req_size  : r_size;
  assign w_s_addr   = w_from_req ? bus.req_addr  : r_addr;
  assign w_s_wdata  = w_from_req ? bus.req_wdata : r_wdata;
  assign w_s_err    = req_is_err(w_s_size, w_s_addr, DEPTH_WORDS);
  assign w_s_off    = lane_offset(w_s_size, w_s_addr[1:0]);

  // Reset on the commit edge wins: the aborted store never reaches the array.
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk     (clk),
    .i_en    (w_go_resp && !w_s_err && !rst),
    .i_we    (w_s_wen),
    .i_be    (byte_en(w_s_size, w_s_off)),
    .i_idx   (w_s_addr[AW+1:2]),
    .i_wdata (steer_wdata(w_s_size, w_s_wdata)),
    .o_rdata (w_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wen   <= 1'b0;
      r_size  <= 2'b00;
      r_sext  <= 1'b0;
      r_off   <= 2'b00;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wen   <= bus.req_wen;
            r_size  <= bus.req_size;
            r_sext  <= bus.req_sign_ext;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_off   <= w_s_off;
            r_err   <= w_s_err;
            r_cnt   <= '0;
            r_state <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (w_go_resp) r_state <= RESP;
          else           r_cnt   <= r_cnt + 1'b1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_err   = (r_state == RESP) && r_err;
  assign bus.resp_rdata = ((r_state == RESP) && !r_err && !r_wen) ?
                          extend(r_size, r_sext, r_off, w_q) : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder: vector table through a
//             LATENCY=2 instance with a response scoreboard, reset abort, and
//             back-to-back issue spacing on LATENCY=1 and LATENCY=3 instances.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus ();
  dmem_responder_if if1 ();
  dmem_responder_if if3 ();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1))   dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3))   dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic wen, input logic [1:0] size, input logic sext,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input logic err);
    vec_t v;
    v.wen = wen; v.size = size; v.sext = sext; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.err = err;
    tbl.push_back(v);
  endtask

  // Scoreboard consumer: every resp_valid pulse must match the oldest entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious resp_valid", {31'b0, bus.resp_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d resp_rdata", e.id), bus.resp_rdata, e.rdata);
        chk($sformatf("vec%0d resp_err", e.id), {31'b0, bus.resp_err}, {31'b0, e.err});
        chk($sformatf("vec%0d resp cycle", e.id), cyc, e.cyc);
      end
    end
  end

  task automatic do_req(input int id, input vec_t v);
    int   n;
    exp_t e;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_wen      = v.wen;
    bus.req_size     = v.size;
    bus.req_sign_ext = v.sext;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk($sformatf("vec%0d req_ready timeout", id), {31'b0, bus.req_ready}, 32'h1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    e.id = id; e.rdata = v.rdata; e.err = v.err; e.cyc = cyc + LAT - 1;
    sb.push_back(e);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk($sformatf("vec%0d response timeout", id), 32'h0, 32'h1);
      sb.delete();
    end
  endtask

  int acc1, acc3, rsp1, rsp3, last1, last3;

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 0; bus.req_wen = 0; bus.req_size = 0; bus.req_sign_ext = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    if1.req_valid = 0; if1.req_wen = 1; if1.req_size = SZ_WORD; if1.req_sign_ext = 0;
    if1.req_addr = 32'h40; if1.req_wdata = 32'h5;
    if3.req_valid = 0; if3.req_wen = 1; if3.req_size = SZ_WORD; if3.req_sign_ext = 0;
    if3.req_addr = 32'h40; if3.req_wdata = 32'h5;

    // wen size sext addr wdata exp_rdata exp_err
    add(1, SZ_WORD, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    add(1, SZ_WORD, 0, 32'h10,  32'h0,        32'h0,        0);
    add(1, SZ_BYTE, 0, 32'h13,  32'h55555580, 32'h0,        0);
    add(0, SZ_BYTE, 1, 32'h13,  32'h0,        32'hFFFFFF80, 0);
    add(0, SZ_BYTE, 0, 32'h13,  32'h0,        32'h00000080, 0);
    add(0, SZ_WORD, 0, 32'h10,  32'h0,        32'h80000000, 0);
    add(1, SZ_WORD, 0, 32'h20,  32'hCAFEF00D, 32'h0,        0);
    add(1, SZ_HALF, 0, 32'h22,  32'hFFFF1234, 32'h0,        0);
    add(0, SZ_HALF, 0, 32'h22,  32'h0,        32'h00001234, 0);
    add(0, SZ_WORD, 0, 32'h20,  32'h0,        32'h1234F00D, 0);
    add(0, SZ_HALF, 1, 32'h20,  32'h0,        32'hFFFFF00D, 0);
    add(0, SZ_BYTE, 0, 32'h21,  32'h0,        32'h000000F0, 0);
    add(0, SZ_BYTE, 1, 32'h20,  32'h0,        32'h0000000D, 0);
`ifdef DMEM_MISALIGN_CHK_EN
    add(0, SZ_WORD, 0, 32'h11,  32'h0,        32'h0,        1);
    add(1, SZ_HALF, 0, 32'h23,  32'h0000BEEF, 32'h0,        1);
    add(0, SZ_WORD, 0, 32'h20,  32'h0,        32'h1234F00D, 0);
`else
    add(0, SZ_WORD, 0, 32'h11,  32'h0,        32'h80000000, 0);
    add(1, SZ_HALF, 0, 32'h23,  32'h0000BEEF, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'h20,  32'h0,        32'hBEEFF00D, 0);
`endif
    add(1, SZ_RSVD, 0, 32'h10,  32'hFFFFFFFF, 32'h0,        1);
    add(0, SZ_RSVD, 1, 32'h10,  32'h0,        32'h0,        1);
    add(1, SZ_WORD, 0, 32'h1000, 32'h12345678, 32'h0,       1);
    add(0, SZ_WORD, 0, 32'h1000, 32'h0,       32'h0,        1);
    add(0, SZ_WORD, 0, 32'hFFFFFFFC, 32'h0,   32'h0,        1);
    add(0, SZ_WORD, 0, 32'h10,  32'h0,        32'h80000000, 0);
    add(1, SZ_WORD, 0, 32'hFFC, 32'h0BADCAFE, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'hFFC, 32'h0,        32'h0BADCAFE, 0);
    add(1, SZ_WORD, 0, 32'h30,  32'h11111111, 32'h0,        0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("req_ready during reset", {31'b0, bus.req_ready}, 32'h0);
    rst = 1'b0;
    #1;
    chk("req_ready after reset", {31'b0, bus.req_ready}, 32'h1);
    chk("resp_valid after reset", {31'b0, bus.resp_valid}, 32'h0);
    chk("resp_rdata after reset", bus.resp_rdata, 32'h0);
    chk("resp_err after reset", {31'b0, bus.resp_err}, 32'h0);

    foreach (tbl[i]) do_req(i, tbl[i]);

    // Reset while a store to 0x30 is waiting: the store must be dropped.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_size = SZ_WORD;
    bus.req_addr = 32'h30; bus.req_wdata = 32'h22222222;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort req_ready in reset", {31'b0, bus.req_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("abort resp_valid c%0d", k), {31'b0, bus.resp_valid}, 32'h0);
      chk($sformatf("abort resp_rdata c%0d", k), bus.resp_rdata, 32'h0);
    end
    begin
      vec_t v;
      v.wen = 0; v.size = SZ_WORD; v.sext = 0; v.addr = 32'h30;
      v.wdata = 0; v.rdata = 32'h11111111; v.err = 0;
      do_req(100, v);
    end

    // Held req_valid: accepts spaced LATENCY+1 cycles, one response each.
    acc1 = 0; acc3 = 0; rsp1 = 0; rsp3 = 0; last1 = -1; last3 = -1;
    @(negedge clk);
    if1.req_valid = 1'b1;
    if3.req_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (if1.resp_valid === 1'b1) rsp1++;
      if (if3.resp_valid === 1'b1) rsp3++;
      if (i < 40) begin
        if (if1.req_valid && if1.req_ready === 1'b1) begin
          if (last1 >= 0) chk($sformatf("L1 issue gap @%0d", i), i - last1, 2);
          last1 = i; acc1++;
        end
        if (if3.req_valid && if3.req_ready === 1'b1) begin
          if (last3 >= 0) chk($sformatf("L3 issue gap @%0d", i), i - last3, 4);
          last3 = i; acc3++;
        end
      end
      if (i == 39) begin
        if1.req_valid = 1'b0;
        if3.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("L1 accept count", acc1, 20);
    chk("L3 accept count", acc3, 10);
    chk("L1 resp count", rsp1, acc1);
    chk("L3 resp count", rsp3, acc3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
